// File: rtl/tx_seq_pkg.sv
// Shared types and sizing helpers for the transmit burst sequencer.
// Defaults mirror the production transducer configuration.
package tx_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        FIRE,
        LISTEN,
        DONE
    } state_e;

    localparam int unsigned DEF_NUM_CHANNELS  = 4;
    localparam int unsigned DEF_PERIOD        = 2500;
    localparam int unsigned DEF_BURST_PERIODS = 8;
    localparam int unsigned DEF_LISTEN_CYCLES = 100000;

    // Bits needed for a counter running 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_accumulator.sv
// Modular step accumulator producing one channel phase offset per cycle.
// Steps at or above the carrier period saturate and raise a sticky error.
module phase_accumulator
    import tx_seq_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int unsigned PERIOD       = DEF_PERIOD,
    parameter int unsigned OFFSET_W     = $clog2(PERIOD),
    parameter int unsigned IDX_W        = (NUM_CHANNELS > 1) ?
                                          $clog2(NUM_CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                load_in,
    input  logic [OFFSET_W-1:0] step_in,
    input  logic                dir_in,
    input  logic                en_in,
    output logic [OFFSET_W-1:0] offset_out,
    output logic [IDX_W-1:0]    index_out,
    output logic                valid_out,
    output logic                last_out,
    output logic                err_out
);

    localparam logic [OFFSET_W:0]   PERIOD_X  = (OFFSET_W+1)'(PERIOD);
    localparam logic [OFFSET_W-1:0] PERIOD_M1 = OFFSET_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0]    LAST_K    = IDX_W'(NUM_CHANNELS - 1);

    logic [OFFSET_W-1:0] acc_q, acc_d;
    logic [OFFSET_W-1:0] step_q, step_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic                dir_q, dir_d;
    logic                err_q, err_d;
    logic [OFFSET_W:0]   sum;

    always_comb begin
        acc_d  = acc_q;
        step_d = step_q;
        k_d    = k_q;
        dir_d  = dir_q;
        err_d  = err_q;
        sum    = {1'b0, acc_q} + {1'b0, step_q};
        if (load_in) begin
            acc_d = '0;
            k_d   = '0;
            dir_d = dir_in;
            if ({1'b0, step_in} >= PERIOD_X) begin
                step_d = PERIOD_M1;
                err_d  = 1'b1;
            end else begin
                step_d = step_in;
                err_d  = 1'b0;
            end
        end else if (en_in) begin
            // Single conditional subtract keeps the sum inside one period.
            if (sum >= PERIOD_X) begin
                acc_d = OFFSET_W'(sum - PERIOD_X);
            end else begin
                acc_d = sum[OFFSET_W-1:0];
            end
            k_d = k_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_q  <= '0;
            step_q <= '0;
            k_q    <= '0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
            k_q    <= k_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
        end
    end

    assign offset_out = acc_q;
    assign index_out  = dir_q ? (LAST_K - k_q) : k_q;
    assign valid_out  = en_in;
    assign last_out   = (k_q == LAST_K);
    assign err_out    = err_q;

endmodule

// File: rtl/tx_burst_sequencer.sv
// Sequences one transmit burst: load phase offsets, arm, fire the pwm bank,
// then hold a listen window for the receive path.
module tx_burst_sequencer
    import tx_seq_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS           = DEF_NUM_CHANNELS,
    parameter int unsigned PERIOD_IN_CLOCK_CYCLES = DEF_PERIOD,
    parameter int unsigned BURST_PERIODS          = DEF_BURST_PERIODS,
    parameter int unsigned LISTEN_CYCLES          = DEF_LISTEN_CYCLES,
    parameter int unsigned OFFSET_W               =
                                    $clog2(PERIOD_IN_CLOCK_CYCLES)
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             start_in,
    input  logic [OFFSET_W-1:0]              step_in,
    input  logic                             dir_in,
    input  logic                             abort_in,
    output logic                             ready_out,
    output logic [NUM_CHANNELS-1:0]          pwm_rst_out,
    output logic [NUM_CHANNELS*OFFSET_W-1:0] offset_out,
    output logic                             tx_active_out,
    output logic                             listen_out,
    output logic                             done_out,
    output logic                             step_err_out
);

    localparam int unsigned FIRE_LEN = BURST_PERIODS * PERIOD_IN_CLOCK_CYCLES;
    localparam int unsigned CNT_MAX  = (FIRE_LEN > LISTEN_CYCLES) ?
                                       FIRE_LEN : LISTEN_CYCLES;
    localparam int unsigned CNT_W    = cnt_w(CNT_MAX);
    localparam int unsigned IDX_W    = (NUM_CHANNELS > 1) ?
                                       $clog2(NUM_CHANNELS) : 1;

    localparam logic [CNT_W-1:0] FIRE_LAST   = CNT_W'(FIRE_LEN - 1);
    localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_CHANNELS*OFFSET_W-1:0] offset_q, offset_d;
    logic                            ready_q, ready_d;
    logic [NUM_CHANNELS-1:0]         pwm_rst_q, pwm_rst_d;
    logic                            tx_active_q, tx_active_d;
    logic                            listen_q, listen_d;
    logic                            done_q, done_d;

    logic                accept;
    logic                acc_en;
    logic [OFFSET_W-1:0] acc_offset;
    logic [IDX_W-1:0]    acc_index;
    logic                acc_valid;
    logic                acc_last;
    logic                acc_err;

    assign accept = (state_q == IDLE) && start_in;
    assign acc_en = (state_q == LOAD);

    phase_accumulator #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .PERIOD       (PERIOD_IN_CLOCK_CYCLES),
        .OFFSET_W     (OFFSET_W),
        .IDX_W        (IDX_W)
    ) u_phase_acc (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load_in    (accept),
        .step_in    (step_in),
        .dir_in     (dir_in),
        .en_in      (acc_en),
        .offset_out (acc_offset),
        .index_out  (acc_index),
        .valid_out  (acc_valid),
        .last_out   (acc_last),
        .err_out    (acc_err)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        if (acc_valid) begin
            offset_d[int'(acc_index)*OFFSET_W +: OFFSET_W] = acc_offset;
        end
        unique case (state_q)
            IDLE: begin
                if (start_in) state_d = LOAD;
            end
            LOAD: begin
                if (acc_last) state_d = ARM;
            end
            ARM: begin
                state_d = FIRE;
                cnt_d   = '0;
            end
            FIRE: begin
                if (cnt_q == FIRE_LAST) begin
                    state_d = LISTEN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LISTEN: begin
                if (cnt_q == LISTEN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort beats every other transition, including the DONE exit.
        if (abort_in && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        ready_d     = (state_d == IDLE);
        pwm_rst_d   = {NUM_CHANNELS{state_d != FIRE}};
        tx_active_d = (state_d == FIRE);
        listen_d    = (state_d == LISTEN);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            offset_q    <= '0;
            ready_q     <= 1'b1;
            pwm_rst_q   <= '1;
            tx_active_q <= 1'b0;
            listen_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            offset_q    <= offset_d;
            ready_q     <= ready_d;
            pwm_rst_q   <= pwm_rst_d;
            tx_active_q <= tx_active_d;
            listen_q    <= listen_d;
            done_q      <= done_d;
        end
    end

    assign ready_out     = ready_q;
    assign pwm_rst_out   = pwm_rst_q;
    assign offset_out    = offset_q;
    assign tx_active_out = tx_active_q;
    assign listen_out    = listen_q;
    assign done_out      = done_q;
    assign step_err_out  = acc_err;

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Directed bench: offset table on a PERIOD=2500 instance, timing, abort
// and async reset sequences on a PERIOD=10 instance.
module tb_tx_burst_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Large-period instance used for offset arithmetic.
    logic        b_rst_n, b_start, b_dir, b_abort;
    logic [11:0] b_step;
    logic        b_ready, b_tx, b_listen, b_done, b_err;
    logic [3:0]  b_pwm;
    logic [47:0] b_off;

    // Short-period instance used for cycle-exact timing.
    logic        s_rst_n, s_start, s_dir, s_abort;
    logic [3:0]  s_step;
    logic        s_ready, s_tx, s_listen, s_done, s_err;
    logic [3:0]  s_pwm;
    logic [15:0] s_off;

    tx_burst_sequencer #(
        .NUM_CHANNELS           (4),
        .PERIOD_IN_CLOCK_CYCLES (2500),
        .BURST_PERIODS          (3),
        .LISTEN_CYCLES          (5)
    ) u_big (
        .clk_in        (clk),
        .rst_n_in      (b_rst_n),
        .start_in      (b_start),
        .step_in       (b_step),
        .dir_in        (b_dir),
        .abort_in      (b_abort),
        .ready_out     (b_ready),
        .pwm_rst_out   (b_pwm),
        .offset_out    (b_off),
        .tx_active_out (b_tx),
        .listen_out    (b_listen),
        .done_out      (b_done),
        .step_err_out  (b_err)
    );

    tx_burst_sequencer #(
        .NUM_CHANNELS           (4),
        .PERIOD_IN_CLOCK_CYCLES (10),
        .BURST_PERIODS          (3),
        .LISTEN_CYCLES          (5)
    ) u_small (
        .clk_in        (clk),
        .rst_n_in      (s_rst_n),
        .start_in      (s_start),
        .step_in       (s_step),
        .dir_in        (s_dir),
        .abort_in      (s_abort),
        .ready_out     (s_ready),
        .pwm_rst_out   (s_pwm),
        .offset_out    (s_off),
        .tx_active_out (s_tx),
        .listen_out    (s_listen),
        .done_out      (s_done),
        .step_err_out  (s_err)
    );

    typedef struct {
        logic [11:0] step;
        logic        dir;
        logic [47:0] off;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // {ready, pwm_rst[3:0], tx_active, listen, done}
    function automatic logic [7:0] s_stat();
        return {s_ready, s_pwm, s_tx, s_listen, s_done};
    endfunction

    function automatic logic [7:0] exp_stat(input int c);
        logic f;
        f = (c >= 6) && (c <= 35);
        return {(c == 0) || (c >= 42), f ? 4'h0 : 4'hF, f,
                (c >= 36) && (c <= 40), c == 41};
    endfunction

    task automatic wait_b_ready();
        int k = 0;
        while (!b_ready && k < 100) begin
            tick();
            k++;
        end
        chk("big idle wait", b_ready, 1);
    endtask

    task automatic wait_s_ready();
        int k = 0;
        while (!s_ready && k < 100) begin
            tick();
            k++;
        end
        chk("small idle wait", s_ready, 1);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        wait_b_ready();
        b_start = 1'b1;
        b_step  = v.step;
        b_dir   = v.dir;
        tick();
        b_start = 1'b0;
        b_step  = 12'hFFF;
        chk($sformatf("v%0d ready low", i), b_ready, 0);
        repeat (4) tick();
        chk($sformatf("v%0d offsets", i), b_off, v.off);
        chk($sformatf("v%0d step_err", i), b_err, v.err);
        chk($sformatf("v%0d arm pwm_rst", i), b_pwm, 4'hF);
        tick();
        chk($sformatf("v%0d fire", i), {b_pwm, b_tx}, {4'h0, 1'b1});
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;
        chk($sformatf("v%0d abort idle", i), {b_ready, b_pwm, b_done},
            {1'b1, 4'hF, 1'b0});
        chk($sformatf("v%0d offs kept", i), b_off, v.off);
        chk($sformatf("v%0d err kept", i), b_err, v.err);
    endtask

    task automatic s_load(input logic [3:0] st, input logic d,
                          input logic [15:0] off, input logic e,
                          input string nm);
        wait_s_ready();
        s_start = 1'b1;
        s_step  = st;
        s_dir   = d;
        tick();
        s_start = 1'b0;
        repeat (4) tick();
        chk({nm, " offsets"}, s_off, off);
        chk({nm, " err"}, s_err, e);
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
    endtask

    initial begin
        int first_done;

        vecs[0] = '{12'd700,  1'b0, {12'd2100, 12'd1400, 12'd700,  12'd0},    1'b0};
        vecs[1] = '{12'd900,  1'b1, {12'd0,    12'd900,  12'd1800, 12'd200},  1'b0};
        vecs[2] = '{12'd3000, 1'b0, {12'd2497, 12'd2498, 12'd2499, 12'd0},    1'b1};
        vecs[3] = '{12'd700,  1'b0, {12'd2100, 12'd1400, 12'd700,  12'd0},    1'b0};
        vecs[4] = '{12'd2500, 1'b1, {12'd0,    12'd2499, 12'd2498, 12'd2497}, 1'b1};
        vecs[5] = '{12'd0,    1'b0, {12'd0,    12'd0,    12'd0,    12'd0},    1'b0};
        vecs[6] = '{12'd2499, 1'b0, {12'd2497, 12'd2498, 12'd2499, 12'd0},    1'b0};
        vecs[7] = '{12'd1250, 1'b1, {12'd0,    12'd1250, 12'd0,    12'd1250}, 1'b0};

        b_rst_n = 1'b0; b_start = 1'b0; b_dir = 1'b0; b_abort = 1'b0;
        b_step  = '0;
        s_rst_n = 1'b0; s_start = 1'b0; s_dir = 1'b0; s_abort = 1'b0;
        s_step  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        b_rst_n = 1'b1;
        s_rst_n = 1'b1;
        tick();

        chk("reset status", {b_ready, b_pwm, b_tx, b_listen, b_done},
            {1'b1, 4'hF, 3'b000});
        chk("reset offsets", b_off, 48'h0);
        chk("reset step_err", b_err, 0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Full burst timing with an ignored start during FIRE.
        wait_s_ready();
        s_start = 1'b1;
        s_step  = 4'd3;
        tick();
        s_start = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            chk($sformatf("timing c%0d", c), s_stat(), exp_stat(c));
            s_start = (c == 10);
            tick();
        end
        s_start = 1'b0;
        chk("burst offsets", s_off, 16'h9630);

        // Abort mid-FIRE, immediate restart, done only for the restart.
        wait_s_ready();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (19) tick();
        chk("c20 firing", s_tx, 1);
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        chk("c21 aborted", s_stat(), {1'b1, 4'hF, 3'b000});
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("c22 restart", s_ready, 0);
        first_done = -1;
        for (int c = 22; c <= 70; c++) begin
            if (s_done && first_done < 0) first_done = c;
            tick();
        end
        chk("restart done cycle", first_done, 62);

        // Abort alone in IDLE is ignored; start with abort is accepted.
        wait_s_ready();
        s_abort = 1'b1;
        tick();
        chk("idle abort ignored", s_ready, 1);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("start+abort accepted", s_ready, 0);
        tick();
        s_abort = 1'b0;
        chk("abort in load", {s_ready, s_pwm, s_done}, {1'b1, 4'hF, 1'b0});

        s_load(4'd4,  1'b0, 16'h2840, 1'b0, "small step4");
        s_load(4'd12, 1'b0, 16'h7890, 1'b1, "small sat");

        // Asynchronous reset in the listen window.
        wait_s_ready();
        s_start = 1'b1;
        s_step  = 4'd3;
        tick();
        s_start = 1'b0;
        repeat (37) tick();
        chk("c38 listening", s_stat(), exp_stat(38));
        #2;
        s_rst_n = 1'b0;
        #1;
        chk("async reset status", s_stat(), {1'b1, 4'hF, 3'b000});
        chk("async reset offsets", s_off, 16'h0);
        @(negedge clk);
        s_rst_n = 1'b1;
        tick();
        tick();
        chk("post reset idle", s_stat(), {1'b1, 4'hF, 3'b000});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_burst_sequencer.md
Name: tx_burst_sequencer

Overview:
- Sequences one ultrasonic transmit burst across NUM_CHANNELS pwm instances.
- On each accepted start it computes the per-channel phase offsets for the requested steering step and holds the pwm instances in reset while their default_offset inputs settle.
- It then releases them for exactly BURST_PERIODS carrier periods and opens a listen window for the receive path.
- It sits between the steering/angle logic and the transducer pwm bank.

Parameters:
- NUM_CHANNELS, 4: number of transducer channels / pwm instances.
- PERIOD_IN_CLOCK_CYCLES, 2500: carrier period in clocks; must match the pwm instances.
- BURST_PERIODS, 8: carrier periods per burst.
- LISTEN_CYCLES, 100000: clocks that listen_out is held high after the burst.
- OFFSET_W, $clog2(PERIOD_IN_CLOCK_CYCLES): width of one phase offset.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  burst request; accepted only while ready_out=1.
- step_in  input  OFFSET_W  inter-channel phase step in clocks; sampled on accept.
- dir_in  input  1  0: offset grows with channel index; 1: reversed order; sampled on accept.
- abort_in  input  1  cancel the burst in progress.
- ready_out  output  1  high in IDLE only.
- pwm_rst_out  output  NUM_CHANNELS  active-high sync reset to each pwm; low only in FIRE.
- offset_out  output  NUM_CHANNELS*OFFSET_W  flattened default_offset per channel; channel i at bits [i*OFFSET_W +: OFFSET_W].
- tx_active_out  output  1  high in FIRE.
- listen_out  output  1  high in LISTEN.
- done_out  output  1  one-cycle pulse at the end of a completed burst.
- step_err_out  output  1  sticky until the next accept; set when the sampled step_in was ≥ PERIOD.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, all counters 0, offset_out all 0, pwm_rst_out all 1.
  - ready_out=1; tx_active_out, listen_out, done_out, step_err_out all 0.
- States and transitions:
  - IDLE → LOAD on start_in. The accept cycle latches step and dir.
  - If step_in ≥ PERIOD: step saturates to PERIOD-1 and step_err_out=1; otherwise step_err_out=0.
  - LOAD lasts NUM_CHANNELS cycles and computes one channel per cycle by accumulation: acc starts at 0; offset[k]=acc; acc_next=acc+step, minus PERIOD if ≥ PERIOD.
  - The adder is OFFSET_W+1 bits wide. There is no multiplier.
  - k counts 0..N-1. The channel written is k when dir=0, or N-1-k when dir=1.
  - LOAD → ARM: one cycle. pwm_rst_out is still 1 and offsets are stable.
  - ARM → FIRE: FIRE lasts BURST_PERIODS*PERIOD_IN_CLOCK_CYCLES cycles. pwm_rst_out=0 and tx_active_out=1.
  - FIRE → LISTEN: LISTEN lasts LISTEN_CYCLES cycles with listen_out=1. pwm_rst_out=1 again.
  - LISTEN → DONE: one cycle with done_out=1, then → IDLE.
- Latency: with the accept at cycle t:
  - ready_out is 0 from t+1.
  - LOAD runs t+1..t+N and ARM is t+N+1.
  - FIRE starts at t+N+2. pwm_rst_out is 0 exactly during the FIRE cycles.
- offset_out holds its value from the end of LOAD until the next accept's LOAD overwrites it.
- abort_in in any non-IDLE state:
  - Next state is IDLE and pwm_rst_out=1 immediately in that next cycle.
  - No done pulse is issued. offset_out is retained.
  - abort_in has priority over every other transition, including the DONE exit.
- abort_in in IDLE is ignored. start_in in a non-IDLE state is ignored and not queued.
- start_in together with abort_in in IDLE: the start is accepted.
- Fire and listen counters are wide enough for the product of their parameters. The terminal count is compared exactly, with no off-by-one.
- step=0 gives all offsets 0 (broadside). No special case is needed.

Decomposition:
- Package tx_seq_pkg:
  - state enum {IDLE, LOAD, ARM, FIRE, LISTEN, DONE}.
  - Counter width localparams derived from the parameters.
- One sub-module, phase_accumulator: modular step accumulator with saturation/err logic and outputs (offset, index, valid).

Test Plan (NUM_CHANNELS=4, PERIOD=10 unless noted; BURST_PERIODS=3, LISTEN_CYCLES=5):
- PERIOD=2500, step=700, dir=0 → offsets ch0..3 = 0, 700, 1400, 2100; step_err_out=0.
- PERIOD=2500, step=900, dir=1 → ch3=0, ch2=900, ch1=1800, ch0=200 (2700 wrap).
- PERIOD=2500, step=3000 → saturates to 2499; offsets 0, 2499, 2498, 2497; step_err_out=1, cleared by the next valid accept.
- Start at cycle 0:
  - ready_out=0 from cycle 1.
  - pwm_rst_out=0 and tx_active_out=1 for cycles 6..35 (30 cycles).
  - listen_out=1 for cycles 36..40.
  - done_out=1 at cycle 41; ready_out=1 at cycle 42.
  - A start_in pulse at cycle 10 has no effect.
- abort_in at cycle 20 (mid-FIRE) → pwm_rst_out all 1 and IDLE at cycle 21; no done_out; a new start at cycle 21 is accepted.
- rst_n_in low asynchronously mid-LISTEN → outputs at reset values within the same cycle; after release the block is idle with ready_out=1.
